// File: rtl/alu_result_forwarder.sv
// alu_result_forwarder
//   Result-side pipeline behind the ALU. Each accepted ALU result moves through
//   a MEM slot (S1) and a WB slot (S2). From S2 it goes to the register-file
//   write port over a valid/ready handshake. Every cycle the block also drives
//   the forwarding data and select for the ALU operand muxes.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ex_valid/ex_ready   EX result handshake (ex_result, ex_rd, ex_wb_en)
//   wb_valid/wb_ready   register-file write handshake (wb_data, wb_rd)
//   src_rs              source register of the operand being selected
//   fwd_data/fwd_select forwarded value and hit flag for the operand mux
//   hazard_stall        operand is not forwardable; EX must hold
//
// Configuration
//   ALU_FWD_WB_SLOT_EN  defined:   S1 and S2 both forward, hazard_stall = 0
//                       undefined: only S1 forwards, and an S2-only match
//                                  raises hazard_stall until the write retires

module alu_result_forwarder #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wb_en,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_rd,
  input  logic [REG_AW-1:0] src_rs,
  output logic [DATA_W-1:0] fwd_data,
  output logic              fwd_select,
  output logic              hazard_stall
);

  logic              s1_valid_q, s1_valid_d;
  logic              s1_wb_en_q, s1_wb_en_d;
  logic [REG_AW-1:0] s1_rd_q,    s1_rd_d;
  logic [DATA_W-1:0] s1_data_q,  s1_data_d;

  logic              s2_valid_q, s2_valid_d;
  logic              s2_wb_en_q, s2_wb_en_d;
  logic [REG_AW-1:0] s2_rd_q,    s2_rd_d;
  logic [DATA_W-1:0] s2_data_q,  s2_data_d;

  logic s2_retire;
  logic s2_load;
  logic s1_load;
  logic m1;
  logic m2;
  logic src_nz;

  // A non-writing entry in S2 drains on its own, without waiting for wb_ready.
  assign s2_retire = s2_valid_q & (~s2_wb_en_q | wb_ready);
  // S2 loading is the same event as S1 moving out.
  assign s2_load   = s1_valid_q & (~s2_valid_q | s2_retire);
  assign ex_ready  = ~s1_valid_q | s2_load;
  assign s1_load   = ex_valid & ex_ready;

  assign wb_valid  = s2_valid_q & s2_wb_en_q;
  assign wb_data   = s2_data_q;
  assign wb_rd     = s2_rd_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_wb_en_d = s1_wb_en_q;
    s1_rd_d    = s1_rd_q;
    s1_data_d  = s1_data_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_wb_en_d = ex_wb_en;
      s1_rd_d    = ex_rd;
      s1_data_d  = ex_result;
    end else if (s2_load) begin
      // Vacated and not refilled: drop valid and keep the payload.
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_wb_en_d = s2_wb_en_q;
    s2_rd_d    = s2_rd_q;
    s2_data_d  = s2_data_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_wb_en_d = s1_wb_en_q;
      s2_rd_d    = s1_rd_q;
      s2_data_d  = s1_data_q;
    end else if (s2_retire) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_wb_en_q <= 1'b0;
      s1_rd_q    <= '0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_wb_en_q <= 1'b0;
      s2_rd_q    <= '0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_wb_en_q <= s1_wb_en_d;
      s1_rd_q    <= s1_rd_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_wb_en_q <= s2_wb_en_d;
      s2_rd_q    <= s2_rd_d;
      s2_data_q  <= s2_data_d;
    end
  end

  // Register 0 is hardwired zero, so it never matches a forwarding source.
  assign src_nz = |src_rs;
  assign m1 = s1_valid_q & s1_wb_en_q & (s1_rd_q == src_rs) & src_nz;
  assign m2 = s2_valid_q & s2_wb_en_q & (s2_rd_q == src_rs) & src_nz;

`ifdef ALU_FWD_WB_SLOT_EN
  // S1 holds the younger entry, so it takes priority over S2.
  assign fwd_select   = m1 | m2;
  assign fwd_data     = m1 ? s1_data_q : (m2 ? s2_data_q : '0);
  assign hazard_stall = 1'b0;
`else
  assign fwd_select   = m1;
  assign fwd_data     = m1 ? s1_data_q : '0;
  assign hazard_stall = m2 & ~m1;
`endif

endmodule
